// File: rtl/axis_snapshot_ctrl.sv
// Snapshot capture sequencer for an AXI4-Stream sample tap.
// Arm, hold off N beats, then capture on trigger or timeout.
module axis_snapshot_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int TS_WIDTH         = 48
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_arm,
    input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
    input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
    input  logic                        trig_flag,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] snap_data,
    output logic [TS_WIDTH-1:0]         snap_ts,
    output logic [1:0]                  sts_state,
    output logic                        sts_done,
    output logic                        sts_timeout,
    output logic [15:0]                 sts_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_ARMED   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic                        arm_q;
    logic [CNTR_WIDTH-1:0]       holdoff_q, holdoff_d;
    logic [CNTR_WIDTH-1:0]       tmo_q, tmo_d;
    logic [CNTR_WIDTH-1:0]       cnt_q, cnt_d;
    logic [TS_WIDTH-1:0]         ts_q, ts_d;
    logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
    logic [TS_WIDTH-1:0]         sts_ts_q, sts_ts_d;
    logic                        done_q, done_d;
    logic                        to_q, to_d;
    logic [15:0]                 count_q, count_d;

    logic arm_edge;
    logic capture;
    logic cap_to;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            arm_q     <= 1'b1;
            holdoff_q <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            ts_q      <= '0;
            data_q    <= '0;
            sts_ts_q  <= '0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= cfg_arm;
            holdoff_q <= holdoff_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            ts_q      <= ts_d;
            data_q    <= data_d;
            sts_ts_q  <= sts_ts_d;
            done_q    <= done_d;
            to_q      <= to_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sts_ts_d  = sts_ts_q;
        done_d    = done_q;
        to_d      = to_q;
        count_d   = count_q;
        capture   = 1'b0;
        cap_to    = 1'b0;
        arm_edge  = cfg_arm & ~arm_q;
        ts_d      = s_axis_tvalid ? ts_q + TS_WIDTH'(1) : ts_q;

        // Abort on a dropped arm level takes priority over any capture.
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_edge) begin
                    state_d   = ST_HOLDOFF;
                    holdoff_d = cfg_holdoff;
                    tmo_d     = cfg_timeout;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    to_d      = 1'b0;
                end
            end
            ST_HOLDOFF: begin
                if (!cfg_arm) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == holdoff_q) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else if (s_axis_tvalid) begin
                    cnt_d = cnt_q + CNTR_WIDTH'(1);
                end
            end
            ST_ARMED: begin
                if (!cfg_arm) begin
                    state_d = ST_IDLE;
                end else if (s_axis_tvalid) begin
                    if (trig_flag) begin
                        capture = 1'b1;
                    end else if (tmo_q != '0 &&
                                 cnt_q == tmo_q - CNTR_WIDTH'(1)) begin
                        capture = 1'b1;
                        cap_to  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            state_d  = ST_DONE;
            data_d   = s_axis_tdata;
            sts_ts_d = ts_q;
            done_d   = 1'b1;
            to_d     = cap_to;
            count_d  = count_q + 16'd1;
        end
    end

    assign s_axis_tready = 1'b1;
    assign snap_data     = data_q;
    assign snap_ts       = sts_ts_q;
    assign sts_state     = state_q;
    assign sts_done      = done_q;
    assign sts_timeout   = to_q;
    assign sts_count     = count_q;

endmodule

// File: tb/tb_axis_snapshot_ctrl.sv
// Bench for axis_snapshot_ctrl: directed scenarios plus random
// traffic, all checked per cycle against a behavioural model.
module tb_axis_snapshot_ctrl;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam int TW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_arm;
    logic [CW-1:0] cfg_holdoff;
    logic [CW-1:0] cfg_timeout;
    logic          trig_flag;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] snap_data;
    logic [TW-1:0] snap_ts;
    logic [1:0]    sts_state;
    logic          sts_done;
    logic          sts_timeout;
    logic [15:0]   sts_count;

    always #5 aclk = ~aclk;

    axis_snapshot_ctrl #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH      (CW),
        .TS_WIDTH        (TW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_arm      (cfg_arm),
        .cfg_holdoff  (cfg_holdoff),
        .cfg_timeout  (cfg_timeout),
        .trig_flag    (trig_flag),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .snap_data    (snap_data),
        .snap_ts      (snap_ts),
        .sts_state    (sts_state),
        .sts_done     (sts_done),
        .sts_timeout  (sts_timeout),
        .sts_count    (sts_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 holdoff, 2 armed, 3 done.
    int          m_st      = 0;
    bit          m_arm_prv = 1'b1;
    longint      m_left    = 0;
    longint      m_tmo     = 0;
    longint      m_k       = 0;
    int          m_ts      = 0;
    logic [31:0] m_data    = '0;
    int          m_snap_ts = 0;
    bit          m_done    = 1'b0;
    bit          m_to      = 1'b0;
    int          m_count   = 0;

    task automatic model_edge();
        bit rise;
        int stamp;
        if (!aresetn) begin
            m_st = 0; m_arm_prv = 1'b1; m_left = 0; m_tmo = 0; m_k = 0;
            m_ts = 0; m_data = '0; m_snap_ts = 0;
            m_done = 1'b0; m_to = 1'b0; m_count = 0;
            return;
        end
        rise  = cfg_arm && !m_arm_prv;
        stamp = m_ts;
        if (m_st == 0 || m_st == 3) begin
            if (rise) begin
                m_st   = 1;
                m_left = longint'(cfg_holdoff);
                m_tmo  = longint'(cfg_timeout);
                m_k    = 0;
                m_done = 1'b0;
                m_to   = 1'b0;
            end
        end else if (!cfg_arm) begin
            m_st = 0;
        end else if (m_st == 1) begin
            if (m_left == 0) begin
                m_st = 2;
                m_k  = 0;
            end else if (s_axis_tvalid) begin
                m_left--;
            end
        end else if (s_axis_tvalid) begin
            m_k++;
            if (trig_flag || (m_tmo != 0 && m_k == m_tmo)) begin
                m_st      = 3;
                m_data    = s_axis_tdata;
                m_snap_ts = stamp;
                m_done    = 1'b1;
                m_to      = !trig_flag;
                m_count   = (m_count + 1) % 65536;
            end
        end
        if (s_axis_tvalid) m_ts = (m_ts + 1) % 256;
        m_arm_prv = cfg_arm;
    endtask

    task automatic step();
        model_edge();
        @(posedge aclk);
        #1;
        chk("tready",  s_axis_tready, 1);
        chk("state",   sts_state, m_st);
        chk("done",    sts_done, m_done);
        chk("timeout", sts_timeout, m_to);
        chk("count",   sts_count, m_count);
        chk("data",    snap_data, m_data);
        chk("ts",      snap_ts, m_snap_ts);
    endtask

    initial begin
        int exp_ts;
        aresetn       = 1'b0;
        cfg_arm       = 1'b1;
        cfg_holdoff   = '0;
        cfg_timeout   = '0;
        trig_flag     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;

        repeat (3) step();
        chk("rst_state", sts_state, 0);
        chk("rst_count", sts_count, 0);
        chk("rst_data",  snap_data, 0);
        aresetn = 1'b1;
        repeat (3) step();
        chk("arm_held_idle", sts_state, 0);
        cfg_arm = 1'b0;
        step();
        cfg_arm     = 1'b1;
        cfg_holdoff = 3;
        step();
        chk("arm_edge", sts_state, 1);

        s_axis_tvalid = 1'b1;
        trig_flag     = 1'b1;
        s_axis_tdata  = 32'hA5A5_0001;
        repeat (3) step();
        chk("holdoff_trig_ign", sts_state, 1);
        step();
        chk("armed", sts_state, 2);
        chk("armed_nodone", sts_done, 0);
        step();
        chk("trig_done", sts_done, 1);
        chk("trig_data", snap_data, 32'hA5A5_0001);
        chk("trig_cnt",  sts_count, 1);

        cfg_arm   = 1'b0;
        trig_flag = 1'b0;
        step();
        cfg_arm     = 1'b1;
        cfg_holdoff = 0;
        cfg_timeout = 5;
        step();
        step();
        chk("to_armed", sts_state, 2);
        repeat (4) step();
        chk("to_wait", sts_done, 0);
        step();
        chk("to_done", sts_done, 1);
        chk("to_flag", sts_timeout, 1);
        chk("to_cnt",  sts_count, 2);

        cfg_arm = 1'b0;
        step();
        cfg_arm     = 1'b1;
        cfg_timeout = 1;
        step();
        step();
        trig_flag = 1'b1;
        step();
        chk("tie_done", sts_done, 1);
        chk("tie_flag", sts_timeout, 0);

        cfg_arm   = 1'b0;
        trig_flag = 1'b0;
        step();
        cfg_arm     = 1'b1;
        cfg_holdoff = 2;
        cfg_timeout = 0;
        step();
        repeat (3) step();
        chk("abort_armed", sts_state, 2);
        cfg_arm = 1'b0;
        step();
        chk("abort_idle", sts_state, 0);
        trig_flag    = 1'b1;
        s_axis_tdata = 32'hDEAD_BEEF;
        repeat (5) step();
        chk("abort_nodone", sts_done, 0);
        chk("abort_data",   snap_data, 32'hA5A5_0001);

        trig_flag = 1'b0;
        step();
        cfg_arm     = 1'b1;
        cfg_holdoff = 0;
        step();
        repeat (300) begin
            s_axis_tdata = $urandom;
            step();
        end
        s_axis_tvalid = 1'b0;
        trig_flag     = 1'b1;
        repeat (4) step();
        chk("gap_nocap", sts_done, 0);
        s_axis_tvalid = 1'b1;
        exp_ts        = m_ts;
        step();
        chk("wrap_done", sts_done, 1);
        chk("wrap_ts",   snap_ts, exp_ts);

        for (int i = 0; i < 3000; i++) begin
            aresetn       = ($urandom_range(0, 499) != 0);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            trig_flag     = ($urandom_range(0, 7) == 0);
            s_axis_tdata  = $urandom;
            cfg_holdoff   = $urandom_range(0, 4);
            cfg_timeout   = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) cfg_arm = ~cfg_arm;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
